// File: rtl/image_read_cache_pkg.sv
// Shared types and width helpers for the image read cache.
// Address split is {tag, index, offset}; widths follow from the cache geometry.
package image_read_cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      FILL_REQ,
      FILL,
      RESP
   } state_t;

   function automatic int unsigned off_w(input int unsigned line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int unsigned idx_w(input int unsigned num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int unsigned tag_w(input int unsigned addr_w,
                                         input int unsigned line_bytes,
                                         input int unsigned num_lines);
      return addr_w - off_w(line_bytes) - idx_w(num_lines);
   endfunction

endpackage

// File: rtl/cache_data_ram.sv
// Single-port byte RAM, synchronous read-first behaviour, block-RAM inferable.
module cache_data_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 1024
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/image_read_cache.sv
// Direct-mapped, read-only line cache answering processor byte reads;
// misses fetch the whole line from DDR in one burst.
module image_read_cache
   import image_read_cache_pkg::*;
#(
   parameter int unsigned ADDR_W     = 19,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned LINE_BYTES = 16,
   parameter int unsigned NUM_LINES  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RD_MI,
   input  logic [ADDR_W-1:0] MI_add,
   output logic [DATA_W-1:0] MI_data,
   output logic              d_ready_re,
   input  logic              inv,
   output logic              ddr_rd_req,
   output logic [ADDR_W-1:0] ddr_rd_addr,
   input  logic              ddr_rd_ack,
   input  logic              ddr_rd_valid,
   input  logic [DATA_W-1:0] ddr_rd_data,
   output logic              busy
);

   localparam int unsigned OFF_W = off_w(LINE_BYTES);
   localparam int unsigned IDX_W = idx_w(NUM_LINES);
   localparam int unsigned TAG_W = tag_w(ADDR_W, LINE_BYTES, NUM_LINES);

   state_t              state;
   logic [ADDR_W-1:0]   addr_r;
   logic [OFF_W-1:0]    off_r;
   logic [IDX_W-1:0]    idx_r;
   logic [TAG_W-1:0]    tag_r;
   logic [OFF_W-1:0]    cnt;
   logic                pending_inv;
   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]    tag_mem [NUM_LINES];
   logic                hit;
   logic                fill_last;
   logic                ram_we;
   logic [IDX_W+OFF_W-1:0] ram_addr;
   logic [DATA_W-1:0]   ram_rdata;

   assign off_r = addr_r[OFF_W-1:0];
   assign idx_r = addr_r[OFF_W +: IDX_W];
   assign tag_r = addr_r[ADDR_W-1 -: TAG_W];
   assign hit   = valid[idx_r] && (tag_mem[idx_r] == tag_r);
   assign busy  = (state != IDLE);

   assign fill_last = (state == FILL) && ddr_rd_valid && (cnt == '1);

   // IDLE reads straight from the request port so the byte is ready in LOOKUP.
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = {idx_r, off_r};
      case (state)
         IDLE: ram_addr = MI_add[OFF_W+IDX_W-1:0];
         FILL: begin
            ram_we   = ddr_rd_valid;
            ram_addr = {idx_r, cnt};
         end
         default: ram_addr = {idx_r, off_r};
      endcase
   end

   cache_data_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (NUM_LINES * LINE_BYTES)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ddr_rd_data),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (fill_last) begin
         tag_mem[idx_r] <= tag_r;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         addr_r      <= '0;
         valid       <= '0;
         cnt         <= '0;
         pending_inv <= 1'b0;
         MI_data     <= '0;
         d_ready_re  <= 1'b0;
         ddr_rd_req  <= 1'b0;
         ddr_rd_addr <= '0;
      end else begin
         d_ready_re <= 1'b0;
         if (inv && state != IDLE) begin
            pending_inv <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (inv) begin
                  valid <= '0;
               end
               if (RD_MI) begin
                  addr_r <= MI_add;
                  state  <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  MI_data    <= ram_rdata;
                  d_ready_re <= 1'b1;
                  state      <= RESP;
               end else begin
                  ddr_rd_addr <= {tag_r, idx_r, {OFF_W{1'b0}}};
                  ddr_rd_req  <= 1'b1;
                  state       <= FILL_REQ;
               end
            end
            FILL_REQ: begin
               if (ddr_rd_ack) begin
                  ddr_rd_req <= 1'b0;
                  cnt        <= '0;
                  state      <= FILL;
               end
            end
            FILL: begin
               if (ddr_rd_valid) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == off_r) begin
                     MI_data <= ddr_rd_data;
                  end
                  if (cnt == '1) begin
                     valid[idx_r] <= 1'b1;
                     d_ready_re   <= 1'b1;
                     state        <= RESP;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
               // Deferred invalidate also drops the line filled by this access.
               if (pending_inv || inv) begin
                  valid       <= '0;
                  pending_inv <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_image_read_cache.sv
// Self-checking bench: directed table, reset/invalidate corners, random reads vs a line model.
module tb_image_read_cache;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 8;
   localparam int LB     = 16;
   localparam int NL     = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              RD_MI = 1'b0;
   logic [ADDR_W-1:0] MI_add = '0;
   logic [DATA_W-1:0] MI_data;
   logic              d_ready_re;
   logic              inv = 1'b0;
   logic              ddr_rd_req;
   logic [ADDR_W-1:0] ddr_rd_addr;
   logic              ddr_rd_ack = 1'b0;
   logic              ddr_rd_valid = 1'b0;
   logic [DATA_W-1:0] ddr_rd_data = '0;
   logic              busy;

   always #5 clk = ~clk;

   image_read_cache #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .LINE_BYTES (LB),
      .NUM_LINES  (NL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .RD_MI        (RD_MI),
      .MI_add       (MI_add),
      .MI_data      (MI_data),
      .d_ready_re   (d_ready_re),
      .inv          (inv),
      .ddr_rd_req   (ddr_rd_req),
      .ddr_rd_addr  (ddr_rd_addr),
      .ddr_rd_ack   (ddr_rd_ack),
      .ddr_rd_valid (ddr_rd_valid),
      .ddr_rd_data  (ddr_rd_data),
      .busy         (busy)
   );

   int n_vec = 0;
   int n_bad = 0;

   // DDR image content; key changes on every frame invalidate.
   logic [7:0]  key = 8'h00;
   logic        mdl_valid [NL];
   logic [14:0] mdl_line  [NL];

   function automatic logic [7:0] ddr_byte(input logic [18:0] a, input logic [7:0] k);
      return a[7:0] ^ a[15:8] ^ {a[18:16], 5'b0} ^ k;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic mdl_clear();
      for (int i = 0; i < NL; i++) mdl_valid[i] = 1'b0;
   endtask

   task automatic do_read(input logic [18:0] addr, input int ack_dly, input int gap,
                          input int inv_mode, input int rst_beat,
                          output logic got, output logic [7:0] data, output int lat,
                          output int bursts, output logic [18:0] baddr,
                          output logic exp_miss, output logic [7:0] exp_data,
                          output int exp_lat);
      int          req_wait;
      int          beats;
      int          fill_cyc;
      int          idles;
      logic        acked;
      logic        inv_fired;
      logic        give;
      int          idx;
      logic [14:0] line;
      got = 1'b0; data = '0; lat = 0; bursts = 0; baddr = '0;
      req_wait = 0; beats = 0; fill_cyc = 0; idles = 0;
      acked = 1'b0; inv_fired = 1'b0;
      idx  = int'(addr[9:4]);
      line = addr[18:4];
      if (inv_mode == 1) begin
         @(negedge clk); inv = 1'b1;
         @(negedge clk); inv = 1'b0;
         key = key + 8'h5A;
         mdl_clear();
      end
      @(negedge clk);
      RD_MI  = 1'b1;
      MI_add = addr;
      if (inv_mode == 2) begin
         inv = 1'b1;
         key = key + 8'h5A;
         mdl_clear();
      end
      exp_miss = !(mdl_valid[idx] && mdl_line[idx] == line);
      exp_data = ddr_byte(addr, key);
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge clk);
         inv = 1'b0; ddr_rd_ack = 1'b0; ddr_rd_valid = 1'b0; ddr_rd_data = '0;
         if (d_ready_re) begin
            got = 1'b1; data = MI_data; lat = cyc; RD_MI = 1'b0;
            break;
         end
         if (!acked && ddr_rd_req) begin
            if (req_wait == 0) begin
               bursts++;
               baddr = ddr_rd_addr;
            end
            if (req_wait >= ack_dly) begin
               ddr_rd_ack = 1'b1;
               acked = 1'b1;
            end else begin
               ddr_rd_valid = 1'($urandom_range(0, 1));
               ddr_rd_data  = 8'hEE;
            end
            req_wait++;
         end else if (acked && beats < LB) begin
            if (rst_beat == beats) begin
               rst = 1'b0;
               #1;
               chk("rst_mi_data", 32'(MI_data), 32'h0);
               chk("rst_ready", 32'(d_ready_re), 32'h0);
               chk("rst_req", 32'(ddr_rd_req), 32'h0);
               chk("rst_ddr_addr", 32'(ddr_rd_addr), 32'h0);
               chk("rst_busy", 32'(busy), 32'h0);
               RD_MI = 1'b0;
               @(negedge clk);
               rst = 1'b1;
               mdl_clear();
               break;
            end
            if (inv_mode == 3 && beats == 3 && !inv_fired) begin
               inv = 1'b1;
               inv_fired = 1'b1;
            end
            case (gap)
               0:       give = 1'b1;
               1:       give = (fill_cyc % 2 == 0);
               default: give = 1'($urandom_range(0, 1));
            endcase
            fill_cyc++;
            if (give) begin
               ddr_rd_valid = 1'b1;
               ddr_rd_data  = ddr_byte(baddr + 19'(beats), key);
               beats++;
            end else begin
               idles++;
            end
         end
      end
      RD_MI = 1'b0;
      exp_lat = exp_miss ? (19 + ack_dly + idles) : 2;
      if (got) begin
         mdl_valid[idx] = 1'b1;
         mdl_line[idx]  = line;
         if (inv_fired) begin
            key = key + 8'h5A;
            mdl_clear();
         end
         @(negedge clk);
         chk("ready_one_cycle", 32'(d_ready_re), 32'h0);
         chk("busy_after", 32'(busy), 32'h0);
      end else if (rst_beat < 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL resp_timeout: got no d_ready_re expected response for 0x%0h", addr);
      end
   endtask

   typedef struct {
      logic [18:0] addr;
      int          ack;
      int          gap;
      int          inv_mode;
      logic        miss;
      logic [7:0]  data;
   } vec_t;

   vec_t tbl [14];

   logic        got;
   logic [7:0]  data;
   int          lat;
   int          bursts;
   logic [18:0] baddr;
   logic        exp_miss;
   logic [7:0]  exp_data;
   int          exp_lat;

   initial begin
      tbl[0]  = '{19'h00013, 3, 0, 0, 1'b1, 8'h13};
      tbl[1]  = '{19'h0001F, 0, 0, 0, 1'b0, 8'h1F};
      tbl[2]  = '{19'h00410, 1, 0, 0, 1'b1, 8'h14};
      tbl[3]  = '{19'h00013, 2, 0, 0, 1'b1, 8'h13};
      tbl[4]  = '{19'h002A5, 0, 1, 0, 1'b1, 8'hA7};
      tbl[5]  = '{19'h002AF, 0, 0, 0, 1'b0, 8'hAD};
      tbl[6]  = '{19'h002A0, 0, 0, 0, 1'b0, 8'hA2};
      tbl[7]  = '{19'h00013, 1, 0, 1, 1'b1, 8'h49};
      tbl[8]  = '{19'h00014, 0, 0, 0, 1'b0, 8'h4E};
      tbl[9]  = '{19'h3F7F0, 2, 0, 2, 1'b1, 8'hD3};
      tbl[10] = '{19'h00020, 1, 0, 3, 1'b1, 8'h94};
      tbl[11] = '{19'h00021, 0, 0, 0, 1'b1, 8'h2F};
      tbl[12] = '{19'h3F7F5, 0, 0, 0, 1'b1, 8'h6C};
      tbl[13] = '{19'h3F7F0, 0, 0, 0, 1'b0, 8'h69};

      mdl_clear();
      repeat (3) @(negedge clk);
      chk("reset_mi_data", 32'(MI_data), 32'h0);
      chk("reset_ready", 32'(d_ready_re), 32'h0);
      chk("reset_req", 32'(ddr_rd_req), 32'h0);
      chk("reset_ddr_addr", 32'(ddr_rd_addr), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      rst = 1'b1;

      for (int i = 0; i < 14; i++) begin
         do_read(tbl[i].addr, tbl[i].ack, tbl[i].gap, tbl[i].inv_mode, -1,
                 got, data, lat, bursts, baddr, exp_miss, exp_data, exp_lat);
         if (got) begin
            chk($sformatf("tbl%0d_data", i), 32'(data), 32'(tbl[i].data));
            chk($sformatf("tbl%0d_bursts", i), 32'(bursts), tbl[i].miss ? 32'd1 : 32'd0);
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(exp_lat));
            if (tbl[i].miss)
               chk($sformatf("tbl%0d_burst_addr", i), 32'(baddr), 32'({tbl[i].addr[18:4], 4'h0}));
         end
      end

      // Reset in the middle of a fill, then both the aborted and an older line must refetch.
      do_read(19'h00555, 1, 0, 0, 5, got, data, lat, bursts, baddr, exp_miss, exp_data, exp_lat);
      do_read(19'h00555, 0, 0, 0, -1, got, data, lat, bursts, baddr, exp_miss, exp_data, exp_lat);
      chk("after_rst_data", 32'(data), 32'h5E);
      chk("after_rst_bursts", 32'(bursts), 32'd1);
      do_read(19'h00021, 0, 0, 0, -1, got, data, lat, bursts, baddr, exp_miss, exp_data, exp_lat);
      chk("after_rst_old_data", 32'(data), 32'h2F);
      chk("after_rst_old_bursts", 32'(bursts), 32'd1);

      for (int i = 0; i < 40; i++) begin
         logic [18:0] a;
         int          r;
         int          mode;
         a = {9'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
         r = int'($urandom_range(0, 9));
         mode = (r >= 7) ? (r - 6) : 0;
         do_read(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), mode, -1,
                 got, data, lat, bursts, baddr, exp_miss, exp_data, exp_lat);
         if (got) begin
            chk($sformatf("rnd%0d_data", i), 32'(data), 32'(exp_data));
            chk($sformatf("rnd%0d_bursts", i), 32'(bursts), exp_miss ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/image_read_cache.md
Name: image_read_cache

Overview:
- Memory-side responder for the processor's input-image read port.
- Accepts level read requests (RD_MI, MI_add) and returns a byte on MI_data with a one-cycle d_ready_re strobe.
- Serves hits from a direct-mapped line cache. On a miss, fetches the whole line from DDR through a simple burst-read interface.
- Sits between the processor and the DDR controller read channel in the downsample design.

Parameters:
- ADDR_W, 19: byte address width.
- DATA_W, 8: pixel/byte width.
- LINE_BYTES, 16: bytes per cache line (power of 2); also the DDR burst length in beats.
- NUM_LINES, 64: number of lines (power of 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- RD_MI  in  1  read request; level, held with stable MI_add until d_ready_re.
- MI_add  in  ADDR_W  requested byte address.
- MI_data  out  DATA_W  returned byte; valid when d_ready_re=1, then held until the next response.
- d_ready_re  out  1  one-cycle response strobe.
- inv  in  1  one-cycle pulse: invalidate all lines (new frame).
- ddr_rd_req  out  1  burst request; held until ack.
- ddr_rd_addr  out  ADDR_W  line-aligned burst address; low log2(LINE_BYTES) bits are 0.
- ddr_rd_ack  in  1  request accepted.
- ddr_rd_valid  in  1  beat valid.
- ddr_rd_data  in  DATA_W  beat data, in ascending address order.
- busy  out  1  state != IDLE.

Behaviour:
- Address split:
  - offset = MI_add[log2(LINE_BYTES)-1:0]
  - index = next log2(NUM_LINES) bits
  - tag = remaining upper bits (defaults: 4 / 6 / 9 bits).
- Storage:
  - tag and valid arrays, NUM_LINES entries.
  - data RAM of NUM_LINES*LINE_BYTES bytes with synchronous read.
- Reset: state=IDLE, all valid=0, MI_data=0, d_ready_re=0, ddr_rd_req=0, ddr_rd_addr=0, busy=0, pending_inv=0. An in-flight DDR burst is abandoned; the DDR side shares the same reset.
- FSM states: IDLE, LOOKUP, FILL_REQ, FILL, RESP.
  - IDLE: if RD_MI, latch MI_add and issue the data RAM read, then go to LOOKUP.
  - LOOKUP:
    - Hit (valid[index] && tag match): register the RAM byte into MI_data, go to RESP.
    - Miss: drive ddr_rd_addr = {tag,index,0}, go to FILL_REQ.
  - FILL_REQ: ddr_rd_req=1 until a cycle with ddr_rd_ack=1 (req drops the next cycle), then go to FILL. Beat counter = 0.
  - FILL:
    - Each ddr_rd_valid beat writes data RAM[index][cnt] and increments cnt. Gaps in ddr_rd_valid are tolerated.
    - When cnt == offset, capture the beat into MI_data.
    - On the last beat (cnt == LINE_BYTES-1), write the tag, set valid[index]=1, go to RESP.
  - RESP: d_ready_re=1 for exactly one cycle, then go to IDLE.
- Processor rule: RD_MI must drop in the cycle after d_ready_re; if still high in IDLE it is a new request.
- Latency:
  - Hit: d_ready_re asserted exactly 2 cycles after the cycle RD_MI is first sampled high in IDLE.
  - Miss: 2 + ack wait + LINE_BYTES beats + 1.
- Conflict miss: the line is overwritten; no write-back (read-only cache).
- inv:
  - In IDLE: clears all valid bits in the same edge. A simultaneous RD_MI is still accepted, and its lookup sees the invalidated state (it misses).
  - In any other state: sets pending_inv. The in-flight access completes and its response is delivered. On entry to IDLE, all valid bits are cleared, including the line just filled.
- ddr_rd_valid outside FILL is ignored.

Decomposition:
- Shared package: state encoding, and derived widths OFF_W, IDX_W, TAG_W as functions of the parameters.
- One natural sub-module: cache_data_ram, a single-port byte RAM with synchronous read and write, depth NUM_LINES*LINE_BYTES, inferable to block RAM.
- The FSM and tag/valid arrays stay in the top level.

Test Plan:
- Cold miss:
  - Stimulus: RD_MI, MI_add=0x00013; DDR acks after 3 cycles, then returns bytes 0x10..0x1F at the burst address.
  - Response: ddr_rd_addr=0x00010; MI_data=0x13 with one d_ready_re pulse; busy low after.
- Same-line hit: MI_add=0x0001F after the cold miss -> no ddr_rd_req; d_ready_re exactly 2 cycles after RD_MI; MI_data=0x1F.
- Conflict:
  - Stimulus: read 0x00410 (same index 1, tag 1), then 0x00013 again.
  - Response: both miss, two DDR bursts, correct bytes returned.
- Gapped fill: ddr_rd_valid toggles 1,0,1,0 over the burst -> all 16 bytes stored; a subsequent hit on offset 15 returns the 16th beat.
- Invalidate:
  - inv in IDLE, then read 0x00013 -> miss and refetch.
  - inv during FILL -> current response delivered; the next read of the same line misses.
- Reset mid-fill: rst low during FILL beat 5 -> all outputs 0, state IDLE; re-reading the same address misses and issues ddr_rd_req.
